// File: rtl/jitter_clock_monitor_pkg.sv
// Shared definitions for the jitter clock monitor: FSM state encodings.
package jitter_clock_monitor_pkg;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_MEASURE = 1'b1;

endpackage

// File: rtl/jitter_clock_monitor_sync_edge_detect.sv
// Synchronizer chain for an asynchronous input plus a delayed-flop edge detector.
// Both rising and falling edges raise EDGE for one cycle.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RESETN,
  input  logic D,
  output logic Q,
  output logic EDGE
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   q_d_p1;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      sync_p0 <= '0;
      q_d_p1  <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], D};
      q_d_p1  <= sync_p0[SYNC_STAGES-1];
    end
  end

  assign Q    = sync_p0[SYNC_STAGES-1];
  assign EDGE = Q ^ q_d_p1;

endmodule

// File: rtl/jitter_clock_monitor.sv
// Measures JCLK half-periods in CLK cycles; keeps min/max, short/long histogram
// counts and a sticky stall timeout.
module jitter_clock_monitor
  import jitter_clock_monitor_pkg::*;
#(
  parameter int CNT_WIDTH      = 16,
  parameter int HIST_WIDTH     = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int THRESH         = 15,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic                  JCLK,
  input  logic                  CLEAR,
  output logic                  MEAS_VALID,
  output logic                  MEAS_LEVEL,
  output logic [CNT_WIDTH-1:0]  MEAS_CYCLES,
  output logic [CNT_WIDTH-1:0]  MIN_CYCLES,
  output logic [CNT_WIDTH-1:0]  MAX_CYCLES,
  output logic [HIST_WIDTH-1:0] SHORT_COUNT,
  output logic [HIST_WIDTH-1:0] LONG_COUNT,
  output logic                  TIMEOUT_ERR,
  output logic                  ARMED
);

  localparam logic [CNT_WIDTH-1:0]  CNT_ONES  = '1;
  localparam logic [HIST_WIDTH-1:0] HIST_ONES = '1;
  localparam logic [CNT_WIDTH-1:0]  THRESH_C  = CNT_WIDTH'(THRESH);
  localparam logic [CNT_WIDTH-1:0]  TMO_C     = CNT_WIDTH'(TIMEOUT_CYCLES);

  function automatic logic [CNT_WIDTH-1:0] sat_inc_cnt(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_ONES) ? v : v + CNT_WIDTH'(1);
  endfunction

  function automatic logic [HIST_WIDTH-1:0] sat_inc_hist(input logic [HIST_WIDTH-1:0] v);
    return (v == HIST_ONES) ? v : v + HIST_WIDTH'(1);
  endfunction

  logic                 sync_q;
  logic                 jedge_p0;
  logic [0:0]           state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 meas_p0;
  logic                 tmo_p0;
  logic                 is_short_p0;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .CLK   (CLK),
    .RESETN(RESETN),
    .D     (JCLK),
    .Q     (sync_q),
    .EDGE  (jedge_p0)
  );

  // Stage p0: decide this cycle's event; an edge beats a coincident timeout
  always_comb begin
    meas_p0     = (state == ST_MEASURE) && jedge_p0;
    tmo_p0      = (state == ST_MEASURE) && !jedge_p0 && (cnt == TMO_C);
    is_short_p0 = (cnt <= THRESH_C);
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      cnt <= jedge_p0 ? CNT_WIDTH'(1) : sat_inc_cnt(cnt);
      if (jedge_p0)
        state <= ST_MEASURE;
      else if (tmo_p0)
        state <= ST_IDLE;
    end
  end

  // Stage p1: registered measurement and statistics
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      MEAS_VALID  <= 1'b0;
      MEAS_LEVEL  <= 1'b0;
      MEAS_CYCLES <= '0;
    end else begin
      MEAS_VALID <= meas_p0;
      if (meas_p0) begin
        MEAS_CYCLES <= cnt;
        MEAS_LEVEL  <= ~sync_q;
      end
    end
  end

  // A CLEAR coinciding with a measurement restarts the stats from that measurement
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      MIN_CYCLES  <= CNT_ONES;
      MAX_CYCLES  <= '0;
      SHORT_COUNT <= '0;
      LONG_COUNT  <= '0;
      TIMEOUT_ERR <= 1'b0;
    end else if (CLEAR) begin
      MIN_CYCLES  <= meas_p0 ? cnt : CNT_ONES;
      MAX_CYCLES  <= meas_p0 ? cnt : '0;
      SHORT_COUNT <= (meas_p0 && is_short_p0) ? HIST_WIDTH'(1) : '0;
      LONG_COUNT  <= (meas_p0 && !is_short_p0) ? HIST_WIDTH'(1) : '0;
      TIMEOUT_ERR <= tmo_p0;
    end else begin
      if (meas_p0) begin
        if (cnt < MIN_CYCLES) MIN_CYCLES <= cnt;
        if (cnt > MAX_CYCLES) MAX_CYCLES <= cnt;
        if (is_short_p0)
          SHORT_COUNT <= sat_inc_hist(SHORT_COUNT);
        else
          LONG_COUNT <= sat_inc_hist(LONG_COUNT);
      end
      if (tmo_p0) TIMEOUT_ERR <= 1'b1;
    end
  end

  assign ARMED = (state == ST_MEASURE);

endmodule

// File: tb/tb_jitter_clock_monitor.sv
// Bench for jitter_clock_monitor: a default instance and a narrow instance, each
// compared every cycle against an event-level model of edges, gaps and stats.
module tb_jitter_clock_monitor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic j0 = 1'b0, j1 = 1'b0;
  logic clr0 = 1'b0, clr1 = 1'b0;

  logic        v0, l0, to0, a0;
  logic [15:0] m0, mn0, mx0, sh0, lg0;
  logic        v1, l1, to1, a1;
  logic [3:0]  m1, mn1, mx1;
  logic [1:0]  sh1, lg1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  jitter_clock_monitor u_d (
    .CLK(clk), .RESETN(rst_n), .JCLK(j0), .CLEAR(clr0),
    .MEAS_VALID(v0), .MEAS_LEVEL(l0), .MEAS_CYCLES(m0),
    .MIN_CYCLES(mn0), .MAX_CYCLES(mx0), .SHORT_COUNT(sh0), .LONG_COUNT(lg0),
    .TIMEOUT_ERR(to0), .ARMED(a0)
  );

  jitter_clock_monitor #(
    .CNT_WIDTH(4), .HIST_WIDTH(2), .SYNC_STAGES(3), .THRESH(15), .TIMEOUT_CYCLES(15)
  ) u_s (
    .CLK(clk), .RESETN(rst_n), .JCLK(j1), .CLEAR(clr1),
    .MEAS_VALID(v1), .MEAS_LEVEL(l1), .MEAS_CYCLES(m1),
    .MIN_CYCLES(mn1), .MAX_CYCLES(mx1), .SHORT_COUNT(sh1), .LONG_COUNT(lg1),
    .TIMEOUT_ERR(to1), .ARMED(a1)
  );

  // Per-instance configuration of the model
  int SS[2]   = '{2, 3};
  int TO[2]   = '{1000, 15};
  int CMAX[2] = '{65535, 15};
  int HMAX[2] = '{65535, 3};
  int TH      = 15;

  bit hist[2][8];
  bit armed[2];
  int last_e[2];
  int cyc = 0;
  bit e_valid[2], e_level[2], e_to[2];
  int e_meas[2], e_min[2], e_max[2], nshort[2], nlong[2];

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 8; k++) hist[i][k] = 1'b0;
      armed[i] = 1'b0; e_valid[i] = 1'b0; e_level[i] = 1'b0; e_to[i] = 1'b0;
      e_meas[i] = 0; e_min[i] = CMAX[i]; e_max[i] = 0; nshort[i] = 0; nlong[i] = 0;
      last_e[i] = 0;
    end
  endtask

  // One CLK edge: an input transition is seen SS cycles after it was first sampled
  task automatic model_step(input int i, input bit jin, input bit clr);
    bit e, lvl, meas, tmo;
    int m;
    e    = hist[i][SS[i]-1] != hist[i][SS[i]];
    lvl  = hist[i][SS[i]];
    m    = cyc - last_e[i];
    meas = armed[i] && e;
    tmo  = armed[i] && !e && (m == TO[i]);
    e_valid[i] = meas;
    if (meas) begin e_meas[i] = m; e_level[i] = lvl; end
    if (e) begin armed[i] = 1'b1; last_e[i] = cyc; end
    if (tmo) armed[i] = 1'b0;
    if (clr) begin
      nshort[i] = 0; nlong[i] = 0; e_min[i] = CMAX[i]; e_max[i] = 0; e_to[i] = 1'b0;
    end
    if (meas) begin
      if (m < e_min[i]) e_min[i] = m;
      if (m > e_max[i]) e_max[i] = m;
      if (m <= TH) nshort[i]++; else nlong[i]++;
    end
    if (tmo) e_to[i] = 1'b1;
    for (int k = 7; k > 0; k--) hist[i][k] = hist[i][k-1];
    hist[i][0] = jin;
  endtask

  function automatic int clamp(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else begin
      model_step(0, j0, clr0);
      model_step(1, j1, clr1);
      cyc++;
    end
  end

  always @(negedge clk) begin
    chk("valid0", int'(v0), int'(e_valid[0]));
    chk("level0", int'(l0), int'(e_level[0]));
    chk("meas0",  int'(m0), e_meas[0]);
    chk("min0",   int'(mn0), e_min[0]);
    chk("max0",   int'(mx0), e_max[0]);
    chk("short0", int'(sh0), clamp(nshort[0], HMAX[0]));
    chk("long0",  int'(lg0), clamp(nlong[0], HMAX[0]));
    chk("tmo0",   int'(to0), int'(e_to[0]));
    chk("armed0", int'(a0), int'(armed[0]));
    chk("valid1", int'(v1), int'(e_valid[1]));
    chk("level1", int'(l1), int'(e_level[1]));
    chk("meas1",  int'(m1), e_meas[1]);
    chk("min1",   int'(mn1), e_min[1]);
    chk("max1",   int'(mx1), e_max[1]);
    chk("short1", int'(sh1), clamp(nshort[1], HMAX[1]));
    chk("long1",  int'(lg1), clamp(nlong[1], HMAX[1]));
    chk("tmo1",   int'(to1), int'(e_to[1]));
    chk("armed1", int'(a1), int'(armed[1]));
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hp(input int i, input int n);
    repeat (n) @(negedge clk);
    if (i == 0) j0 = ~j0; else j1 = ~j1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    chk("lit_rst_min0", int'(mn0), 65535);
    chk("lit_rst_min1", int'(mn1), 15);
    chk("lit_rst_valid0", int'(v0), 0);
    chk("lit_rst_armed0", int'(a0), 0);
    rst_n = 1'b1;

    // Steady 10-cycle half-periods; first edge only arms
    repeat (12) hp(0, 10);
    idle(4);
    chk("lit_p1_min0", int'(mn0), 10);
    chk("lit_p1_max0", int'(mx0), 10);
    chk("lit_p1_short0", int'(sh0), 11);
    chk("lit_p1_long0", int'(lg0), 0);
    chk("lit_p1_armed0", int'(a0), 1);

    // Clear, then random 10/20 half-periods
    hp(0, 10);
    fork
      hp(0, 20);
      begin idle(3); clr0 = 1'b1; idle(1); clr0 = 1'b0; end
    join
    hp(0, 10);
    repeat (50) hp(0, ($urandom_range(0, 1) != 0) ? 20 : 10);
    idle(4);
    chk("lit_p2_min0", int'(mn0), 10);
    chk("lit_p2_max0", int'(mx0), 20);

    // Stall -> timeout; next edge re-arms, the one after measures
    idle(1000);
    chk("lit_p3_tmo0", int'(to0), 1);
    chk("lit_p3_armed0", int'(a0), 0);
    hp(0, 10);
    hp(0, 10);
    idle(4);
    chk("lit_p3_meas0", int'(m0), 10);
    chk("lit_p3_armed0b", int'(a0), 1);

    // CLEAR on the same cycle as a 20-cycle measurement
    hp(0, 10);
    hp(0, 20);
    idle(2); clr0 = 1'b1; idle(1); clr0 = 1'b0;
    chk("lit_p4_min0", int'(mn0), 20);
    chk("lit_p4_max0", int'(mx0), 20);
    chk("lit_p4_long0", int'(lg0), 1);
    chk("lit_p4_short0", int'(sh0), 0);
    chk("lit_p4_tmo0", int'(to0), 0);

    // Narrow instance: histogram saturation, then timeout at all-ones count
    repeat (6) hp(1, 5);
    idle(6);
    chk("lit_p5_short1", int'(sh1), 3);
    chk("lit_p5_long1", int'(lg1), 0);
    chk("lit_p5_min1", int'(mn1), 5);
    idle(20);
    chk("lit_p5_tmo1", int'(to1), 1);
    chk("lit_p5_armed1", int'(a1), 0);
    repeat (80) begin
      if ($urandom_range(0, 7) == 0) begin clr1 = 1'b1; idle(1); clr1 = 1'b0; end
      hp(1, $urandom_range(1, 16));
    end
    idle(6);

    // Asynchronous reset in the middle of a half-period
    repeat (3) hp(0, 10);
    idle(5);
    #3 rst_n = 1'b0;
    #1;
    chk("lit_p6_valid0", int'(v0), 0);
    chk("lit_p6_meas0", int'(m0), 0);
    chk("lit_p6_min0", int'(mn0), 65535);
    chk("lit_p6_max0", int'(mx0), 0);
    chk("lit_p6_short0", int'(sh0), 0);
    chk("lit_p6_armed0", int'(a0), 0);
    chk("lit_p6_min1", int'(mn1), 15);
    chk("lit_p6_short1", int'(sh1), 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    chk("lit_p6_valid0b", int'(v0), 0);
    hp(0, 10);
    hp(0, 10);
    idle(4);
    chk("lit_p6_meas0b", int'(m0), 10);

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
